// File: rtl/issue_scoreboard_ctl.sv
// Issue scoreboard controller: gates decoded instructions into the issue
// queue using a per-register busy scoreboard (RAW/WAW), an in-flight limit,
// branch serialization and flush draining. Issued instructions receive a
// wrapping sequence tag; writebacks clear their destination's busy bit.
//
// Handshake: issue_valid is a pure function of the current inputs and state
// and never depends on issue_ready; a transfer (fire) happens on a rising
// clock edge where issue_valid and issue_ready are both high. dec_ready is
// that same fire, telling the decoder its instruction was consumed.
module issue_scoreboard_ctl #(
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 4,
  parameter int TAG_W        = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic             dec_uses_rs,
  input  logic [4:0]       dec_rs_addr,
  input  logic             dec_uses_rt,
  input  logic [4:0]       dec_rt_addr,
  input  logic             dec_uses_rw,
  input  logic [4:0]       dec_rw_addr,
  input  logic             dec_is_branch_jump,
  output logic             dec_ready,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             wb_valid,
  input  logic             wb_uses_rw,
  input  logic [4:0]       wb_rw_addr,
  input  logic             br_resolve,
  input  logic             flush,
  output logic [31:0]      busy_vec,
  output logic [31:0]      stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [31:0]      busy_q, busy_d;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      stall_q;

  logic [31:0] wbclr;
  logic [31:0] eb;
  logic [31:0] setmask;
  logic        hazard;
  logic        wb_dec;
  logic        room;
  logic        fire;

  // Writeback clear mask and same-cycle "effective busy" view of the scoreboard.
  always_comb begin
    wbclr = '0;
    if (wb_valid && wb_uses_rw && (wb_rw_addr != 5'd0)) wbclr[wb_rw_addr] = 1'b1;
    eb = busy_q & ~wbclr;
  end

  // Operand/destination hazard check, issue gating and the handshake.
  always_comb begin
    hazard      = (dec_uses_rs & eb[dec_rs_addr]) |
                  (dec_uses_rt & eb[dec_rt_addr]) |
                  (dec_uses_rw & eb[dec_rw_addr]);
    // A writeback only frees a slot when something is actually in flight.
    wb_dec      = wb_valid & (inflight_q != '0);
    room        = (inflight_q < MAX_CNT) | wb_dec;
    issue_valid = rst_n & dec_valid & (state_q == RUN) & ~flush & ~hazard & room;
    fire        = issue_valid & issue_ready;
    dec_ready   = fire;
  end

  // Next scoreboard and in-flight count; a set on issue wins over a same-cycle clear.
  always_comb begin
    setmask = '0;
    if (fire && dec_uses_rw && (dec_rw_addr != 5'd0)) setmask[dec_rw_addr] = 1'b1;
    busy_d    = (busy_q & ~wbclr) | setmask;
    busy_d[0] = 1'b0;
    inflight_d = inflight_q;
    if (fire && !wb_dec)      inflight_d = inflight_q + CNT_W'(1);
    else if (!fire && wb_dec) inflight_d = inflight_q - CNT_W'(1);
  end

  // FSM next state: branch serialization and flush drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (flush)                          state_d = DRAIN;
        else if (fire && dec_is_branch_jump) state_d = BR_WAIT;
      end
      BR_WAIT: begin
        if (flush)           state_d = DRAIN;
        else if (br_resolve) state_d = RUN;
      end
      DRAIN: begin
        if (!flush && (inflight_q == '0)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State, scoreboard, counters and tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      inflight_q <= '0;
      busy_q     <= '0;
      tag_q      <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      if (fire) tag_q <= tag_q + TAG_W'(1);
      if (dec_valid && !fire && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

`ifdef SIMULATION
  // Flag a writeback arriving with nothing in flight; the counter ignores it.
  always_ff @(posedge clk) begin
    if (rst_n && wb_valid && (inflight_q == '0))
      $error("issue_scoreboard_ctl: writeback with no instruction in flight");
  end
`endif

  assign busy_vec     = busy_q;
  assign issue_tag    = tag_q;
  assign stall_cycles = stall_q;

endmodule

// File: doc/issue_scoreboard_ctl.md
Name: issue_scoreboard_ctl

Overview:
- Sits between the decode stage and the issue/execute queue in mips_core.
- Decides each cycle whether the decoded instruction may issue, using a per-register busy scoreboard (RAW/WAW), an in-flight limit, branch serialization and flush draining.
- Assigns a wrapping sequence tag to each issued instruction and clears scoreboard state on writeback.

Parameters:
- MAX_INFLIGHT, 8, maximum issued-but-not-written-back instructions (1..2^CNT_W-1).
- CNT_W, 4, width of in-flight counter.
- TAG_W, 6, width of issue sequence tag.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid  in  1  decoder output valid.
- dec_uses_rs  in  1  rs read.
- dec_rs_addr  in  5  rs.
- dec_uses_rt  in  1  rt read.
- dec_rt_addr  in  5  rt.
- dec_uses_rw  in  1  register write.
- dec_rw_addr  in  5  destination.
- dec_is_branch_jump  in  1  branch or jump.
- dec_ready  out  1  decode instruction consumed this cycle.
- issue_valid  out  1  instruction may issue.
- issue_ready  in  1  downstream accepts.
- issue_tag  out  TAG_W  sequence tag of the issuing instruction.
- wb_valid  in  1  one instruction completed.
- wb_uses_rw  in  1  completing instruction wrote a register.
- wb_rw_addr  in  5  its destination.
- br_resolve  in  1  outstanding branch/jump resolved.
- flush  in  1  pipeline flush (mispredict).
- busy_vec  out  32  scoreboard state, for debug.
- stall_cycles  out  32  perf counter.

Behaviour:
- Reset (async, rst_n=0): state=RUN, busy_vec=0, inflight=0, issue_tag=0, stall_cycles=0. issue_valid=0 and dec_ready=0 while rst_n=0.
- Writeback clear mask: wbclr = wb_valid & wb_uses_rw & (wb_rw_addr!=0) ? onehot(wb_rw_addr) : 0. Effective busy is eb = busy_vec & ~wbclr, so a same-cycle writeback unblocks the waiting instruction.
- hazard = (uses_rs & eb[rs]) | (uses_rt & eb[rt]) | (uses_rw & eb[rw]). Register 0 never hazards; busy_vec[0] is always 0.
- room = inflight < MAX_INFLIGHT, or a writeback this cycle (wb_valid & inflight!=0).
- issue_valid = rst_n & dec_valid & state==RUN & !flush & !hazard & room. Combinational, 0 cycles latency.
- fire = issue_valid & issue_ready. dec_ready = fire.
- On fire:
  - busy_vec[rw] <= 1 if uses_rw and rw!=0. Set wins over a same-cycle clear of the same register.
  - issue_tag <= issue_tag+1, wrapping at 2^TAG_W.
  - If dec_is_branch_jump: state <= BR_WAIT.
- inflight next value: +1 on fire, -1 on wb_valid, unchanged when both occur.
  - wb_valid with inflight==0: ignored, counter stays 0, $error under SIMULATION.
  - Overflow is impossible because of room.
- State machine:
  - RUN: fire of a branch/jump -> BR_WAIT. flush -> DRAIN.
  - BR_WAIT: no issue. br_resolve -> RUN. flush -> DRAIN (flush beats br_resolve).
  - DRAIN: no issue. inflight==0 next cycle -> RUN (checked on registered value). flush again stays in DRAIN.
  - br_resolve in RUN or DRAIN: ignored.
- Busy bits are not cleared by flush. Flushed instructions still write back, and their writebacks clear the bits.
- stall_cycles += 1 each cycle dec_valid=1 and fire=0 (rst_n high). Saturates at 2^32-1.
- Reset mid-operation: all state cleared immediately, regardless of in-flight instructions.

Test Plan:
- RAW stall: issue "addu $5" (tag 0) with issue_ready=1, then decode "or $6,$5,$0". The second instruction holds issue_valid=0 and stall_cycles counts 1, 2, 3. Assert wb_valid with wb_rw_addr=5: the second instruction fires in that same cycle with tag 1.
- WAW and zero register: writes to $0 are never blocked and busy_vec stays 0. Two back-to-back writes to $7: the second stalls until the writeback of $7.
- In-flight limit: MAX_INFLIGHT=8, independent destinations $1..$8 issue on 8 consecutive cycles. The 9th stalls. A wb_valid for a store (wb_uses_rw=0) lets it fire in that cycle, and inflight remains 8.
- Branch serialization: fire a beq, then decode addu. The addu is blocked in BR_WAIT for 4 cycles, br_resolve is pulsed, and addu fires the following cycle.
- Flush drain: 3 instructions in flight, then pulse flush together with br_resolve. State becomes DRAIN and no issue occurs during 3 writebacks. State returns to RUN one cycle after inflight reaches 0, and busy_vec is 0.
- Tag wrap and reset: TAG_W=6, 64 fires bring issue_tag back to 0. Asserting rst_n=0 mid-stream zeroes busy_vec, inflight and stall_cycles and forces issue_valid=0 asynchronously.
